dual_bram_be: RTL

- Parametrised true dual-port word memory with per-byte write enables, configurable read latency, a write-collision policy and a post-reset hardware clear sweep.
- Successor to the fixed 32-bit, full-word-write dual BRAM.
- Sits between the DMA/AXI side (port 0) and the PE-array buffer controller (port 1) as weight/activation storage.
- Both ports use byte addressing.

---
 rtl/dual_bram_be.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dual_bram_be.sv
// ---------------------------------------------------------------------------
// dual_bram_be
//   True dual-port word memory with per-byte write enables, 1- or 2-cycle
//   read latency, same-word write collision flag and a hardware clear sweep
//   that runs after reset and on request.
//   Port 0 faces the DMA/AXI side, port 1 the PE-array buffer controller.
//
// Parameters
//   DATA_W  word width in bits (multiple of 8)
//   DEPTH   number of words
//   ADDR_W  byte-address width of each port
//   RD_LAT  read latency, 1 or 2
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   clr_req                  pulse: start a clear sweep (READY only)
//   busy                     high while the clear sweep runs
//   pN_en                    access enable
//   pN_W_req[DATA_W/8]       byte write enables, all-zero = read
//   pN_addr[ADDR_W]          byte address (word = addr >> log2(DATA_W/8))
//   pN_W_data[DATA_W]        write data
//   pN_R_data[DATA_W]        read data (read-first on writes), holds when idle
//   pN_R_valid               one-cycle pulse per accepted access
//   collision                registered pulse: both ports wrote the same word
//
// Optional feature (macro DUAL_BRAM_PARITY_EN)
//   Stores one even-parity bit per byte and adds p0_par_err / p1_par_err,
//   aligned with R_valid, high when any byte of the returned word mismatches.
// ---------------------------------------------------------------------------
module dual_bram_be #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 65536,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    output logic                busy,
    input  logic                p0_en,
    input  logic [DATA_W/8-1:0] p0_W_req,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [DATA_W-1:0]   p0_W_data,
    output logic [DATA_W-1:0]   p0_R_data,
    output logic                p0_R_valid,
    input  logic                p1_en,
    input  logic [DATA_W/8-1:0] p1_W_req,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]   p1_W_data,
    output logic [DATA_W-1:0]   p1_R_data,
    output logic                p1_R_valid,
`ifdef DUAL_BRAM_PARITY_EN
    output logic                p0_par_err,
    output logic                p1_par_err,
`endif
    output logic                collision
);

    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int AW  = $clog2(DEPTH);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;

    // Both ports are folded into two-element arrays so the access logic is
    // written once.
    logic              en    [2];
    logic [NB-1:0]     we    [2];
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wd    [2];
    logic [ADDR_W-1:0] word  [2];
    logic              in_rng[2];
    logic [AW-1:0]     idx   [2];
    logic              acc   [2];
    logic              wr    [2];

    assign en[0] = p0_en;      assign en[1] = p1_en;
    assign we[0] = p0_W_req;   assign we[1] = p1_W_req;
    assign addr[0] = p0_addr;  assign addr[1] = p1_addr;
    assign wd[0] = p0_W_data;  assign wd[1] = p1_W_data;

    assign busy = (state_q == S_CLEAR);

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            word[p]   = addr[p] >> OFF;
            in_rng[p] = (word[p] < ADDR_W'(DEPTH));
            idx[p]    = word[p][AW-1:0];
            acc[p]    = !rst && (state_q == S_READY) && en[p];
            // Out-of-range writes are dropped but still return a read of 0.
            wr[p]     = acc[p] && in_rng[p] && (|we[p]);
        end
    end

    // ------------------------------------------------------------------ FSM
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end
            end
            S_READY: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // --------------------------------------------------------------- storage
    // NOTE: the array has no reset; it is zeroed by the clear sweep instead,
    // which keeps it mappable onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];
`ifdef DUAL_BRAM_PARITY_EN
    logic [NB-1:0]     par_mem [DEPTH];

    function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
        logic [NB-1:0] r;
        for (int b = 0; b < NB; b++) r[b] = ^w[b*8 +: 8];
        return r;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[cnt_q] <= '0;
`ifdef DUAL_BRAM_PARITY_EN
            par_mem[cnt_q] <= '0;
`endif
        end else begin
            // Port 1 is applied first so port 0 wins on bytes both enable.
            for (int p = 1; p >= 0; p--) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr[p] && we[p][b]) begin
                        mem[idx[p]][b*8 +: 8] <= wd[p][b*8 +: 8];
`ifdef DUAL_BRAM_PARITY_EN
                        par_mem[idx[p]][b] <= ^wd[p][b*8 +: 8];
`endif
                    end
                end
            end
        end
    end

    // ----------------------------------------------------- read stage 1
    // Reads sample the array in the same edge as writes, so they return the
    // pre-write word (read-first).
    logic [DATA_W-1:0] rd1 [2];
    logic              v1  [2];
`ifdef DUAL_BRAM_PARITY_EN
    logic              pe1 [2];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                rd1[p] <= '0;
                v1[p]  <= 1'b0;
`ifdef DUAL_BRAM_PARITY_EN
                pe1[p] <= 1'b0;
`endif
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                v1[p] <= acc[p];
                if (acc[p]) begin
                    rd1[p] <= in_rng[p] ? mem[idx[p]] : '0;
`ifdef DUAL_BRAM_PARITY_EN
                    pe1[p] <= in_rng[p] && (byte_par(mem[idx[p]]) != par_mem[idx[p]]);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) collision <= 1'b0;
        else     collision <= wr[0] && wr[1] && (idx[0] == idx[1]);
    end

    // ----------------------------------------------------- output stage
    logic [DATA_W-1:0] rd_o [2];
    logic              v_o  [2];
`ifdef DUAL_BRAM_PARITY_EN
    logic              pe_o [2];
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] rd2 [2];
            logic              v2  [2];
`ifdef DUAL_BRAM_PARITY_EN
            logic              pe2 [2];
`endif
            always_ff @(posedge clk) begin
                for (int p = 0; p < 2; p++) begin
                    if (rst) begin
                        rd2[p] <= '0;
                        v2[p]  <= 1'b0;
`ifdef DUAL_BRAM_PARITY_EN
                        pe2[p] <= 1'b0;
`endif
                    end else begin
                        v2[p] <= v1[p];
                        if (v1[p]) begin
                            rd2[p] <= rd1[p];
`ifdef DUAL_BRAM_PARITY_EN
                            pe2[p] <= pe1[p];
`endif
                        end
                    end
                end
            end
            always_comb begin
                for (int p = 0; p < 2; p++) begin
                    rd_o[p] = rd2[p];
                    v_o[p]  = v2[p];
`ifdef DUAL_BRAM_PARITY_EN
                    pe_o[p] = pe2[p];
`endif
                end
            end
        end else begin : g_lat1
            always_comb begin
                for (int p = 0; p < 2; p++) begin
                    rd_o[p] = rd1[p];
                    v_o[p]  = v1[p];
`ifdef DUAL_BRAM_PARITY_EN
                    pe_o[p] = pe1[p];
`endif
                end
            end
        end
    endgenerate

    assign p0_R_data  = rd_o[0];
    assign p1_R_data  = rd_o[1];
    assign p0_R_valid = v_o[0];
    assign p1_R_valid = v_o[1];
`ifdef DUAL_BRAM_PARITY_EN
    assign p0_par_err = pe_o[0];
    assign p1_par_err = pe_o[1];
`endif

endmodule
